div_unit: RTL and testbench

- Parametrised multi-cycle integer divider serving the EX stage for DIV/DIVU.
- Supersedes single-cycle combinational arithmetic in EX.
- Radix-2 restoring algorithm over WIDTH bits, signed and unsigned modes.
- Start/ready handshake plus annul input for pipeline flush.
- Result is packed {remainder, quotient} for a direct write to HI/LO.

---
 rtl/div_unit.sv | 159 +++++++++++++++
 tb/tb_div_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Purpose : multi-cycle radix-2 restoring divider for DIV/DIVU in EX; signed and unsigned modes.
// Latency : start edge E0 -> ready_o after E0+WIDTH+1; divide-by-zero after E0+2; early-out after E0+1.
// Backpr. : start_i is accepted only in FREE; the result is held in END while start_i stays high.
//
// Ports:
//   clk, rst        clock (rising edge) and synchronous active-high reset
//   signed_div_i    1 = signed division, 0 = unsigned
//   opdata1_i       dividend
//   opdata2_i       divisor
//   start_i         request, held high until ready_o is seen
//   annul_i         cancel the operation in flight, or block acceptance while in FREE
//   result_o        {remainder, quotient}
//   ready_o         result_o valid
//   busy_o          high in any state other than FREE
//
// Optional build macro DIV_EARLY_OUT_EN: when |divisor| > |dividend| the iterations are skipped
// and the result is quotient 0, remainder = dividend. Results are identical; only latency differs.
module div_unit #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o
);

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q;      // partial remainder
  logic [WIDTH-1:0] quo_q;      // dividend bits shifting out, quotient bits shifting in
  logic [WIDTH-1:0] dsr_q;      // divisor magnitude
  logic             neg_dvd_q;  // dividend was negative (signed mode)
  logic             neg_quo_q;  // operand signs differ (signed mode)

  logic             dvd_neg, dsr_neg, div_zero, early_out;
  logic [WIDTH-1:0] dvd_mag, dsr_mag;
  logic [WIDTH:0]   shifted, diff;
  logic [WIDTH-1:0] quo_fix, rem_fix, short_rem;

  assign dvd_neg  = signed_div_i & opdata1_i[WIDTH-1];
  assign dsr_neg  = signed_div_i & opdata2_i[WIDTH-1];
  assign dvd_mag  = dvd_neg ? -opdata1_i : opdata1_i;
  assign dsr_mag  = dsr_neg ? -opdata2_i : opdata2_i;
  assign div_zero = (opdata2_i == '0);

`ifdef DIV_EARLY_OUT_EN
  assign early_out = (dsr_mag > dvd_mag);
`else
  assign early_out = 1'b0;
`endif

  // The shifted partial remainder needs WIDTH+1 bits for the trial subtraction. The stored
  // remainder always ends below the divisor magnitude, so WIDTH bits hold it.
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, dsr_q};

  assign quo_fix = neg_quo_q ? -quo_q : quo_q;
  assign rem_fix = neg_dvd_q ? -rem_q : rem_q;
  // On the short path quo_q still holds the dividend magnitude (cleared for divide-by-zero),
  // so restoring its sign gives the original dividend as the remainder.
  assign short_rem = neg_dvd_q ? -quo_q : quo_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FREE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dsr_q     <= '0;
      neg_dvd_q <= 1'b0;
      neg_quo_q <= 1'b0;
      result_o  <= '0;
      ready_o   <= 1'b0;
      busy_o    <= 1'b0;
    end else begin
      case (state)
        FREE: begin
          if (start_i && !annul_i) begin
            neg_dvd_q <= dvd_neg;
            neg_quo_q <= dvd_neg ^ dsr_neg;
            dsr_q     <= dsr_mag;
            quo_q     <= div_zero ? '0 : dvd_mag;
            rem_q     <= '0;
            busy_o    <= 1'b1;
            if (div_zero) begin
              // Two edges through BYZERO: counter runs 0 -> 1.
              state <= BYZERO;
              cnt_q <= '0;
            end else if (early_out) begin
              // Counter preloaded so BYZERO exits on the very next edge.
              state <= BYZERO;
              cnt_q <= CNT_W'(1);
            end else begin
              state <= ON;
              cnt_q <= '0;
            end
          end
        end

        BYZERO: begin
          if (annul_i) begin
            state  <= FREE;
            busy_o <= 1'b0;
          end else if (cnt_q == CNT_W'(1)) begin
            result_o <= {short_rem, {WIDTH{1'b0}}};
            ready_o  <= 1'b1;
            state    <= END;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        ON: begin
          if (annul_i) begin
            state  <= FREE;
            busy_o <= 1'b0;
          end else if (cnt_q == CNT_W'(WIDTH)) begin
            result_o <= {rem_fix, quo_fix};
            ready_o  <= 1'b1;
            state    <= END;
          end else begin
            if (!diff[WIDTH]) begin
              rem_q <= diff[WIDTH-1:0];
              quo_q <= {quo_q[WIDTH-2:0], 1'b1};
            end else begin
              rem_q <= shifted[WIDTH-1:0];
              quo_q <= {quo_q[WIDTH-2:0], 1'b0};
            end
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        END: begin
          if (annul_i || !start_i) begin
            state   <= FREE;
            ready_o <= 1'b0;
            busy_o  <= 1'b0;
          end
        end

        default: begin
          state   <= FREE;
          ready_o <= 1'b0;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Purpose : self-checking bench for div_unit (WIDTH = 32): vector table, random ops, corner sequences.
// Latency : n/a (bench).
// Backpr. : n/a (bench).
module tb_div_unit;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          signed_div_i;
  logic [W-1:0]  opdata1_i;
  logic [W-1:0]  opdata2_i;
  logic          start_i;
  logic          annul_i;
  logic [2*W-1:0] result_o;
  logic          ready_o;
  logic          busy_o;

  int errors = 0;
  int checks = 0;
  logic [63:0] last_res = '0;

  div_unit #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic truncates toward zero with the remainder taking the
  // dividend's sign; most-negative / -1 does not overflow at 64 bits and wraps when cut to 32.
  function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint x, y, q, r;
    int ai, bi;
    if (b == 32'h0) return 64'h0;
    if (sgn) begin
      ai = a; bi = b;
      x = ai; y = bi;
    end else begin
      x = {32'h0, a}; y = {32'h0, b};
    end
    q = x / y;
    r = x % y;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic longint mag(input bit sgn, input logic [31:0] v);
    if (sgn && v[31]) return 64'h1_0000_0000 - {32'h0, v};
    return {32'h0, v};
  endfunction

  function automatic int exp_lat(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'h0) return 2;
`ifdef DIV_EARLY_OUT_EN
    if (mag(sgn, b) > mag(sgn, a)) return 1;
`endif
    return W + 1;
  endfunction

  // Called at posedge+1. Holds start until ready, scrambles operands after the latch edge,
  // holds start in END for two edges, then drops it.
  task automatic run_op(input string name, input bit sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp_res);
    int lat;
    bit busy_bad;
    signed_div_i = sgn; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
    lat = -1; busy_bad = 1'b0;
    @(posedge clk); #1;  // E0
    opdata1_i = $urandom; opdata2_i = $urandom; signed_div_i = ~sgn;
    for (int n = 1; n <= 60 && lat < 0; n++) begin
      @(posedge clk); #1;
      if (busy_o !== 1'b1) busy_bad = 1'b1;
      if (ready_o === 1'b1) lat = n;
    end
    check({name, " latency"}, 64'(lat), 64'(exp_lat(sgn, a, b)));
    check({name, " busy"}, 64'(busy_bad), 64'd0);
    check({name, " result"}, result_o, exp_res);
    repeat (2) @(posedge clk);
    #1;
    check({name, " ready held"}, 64'(ready_o), 64'd1);
    check({name, " result held"}, result_o, exp_res);
    start_i = 1'b0;
    @(posedge clk); #1;
    check({name, " ready drop"}, 64'(ready_o), 64'd0);
    check({name, " busy drop"}, 64'(busy_o), 64'd0);
    check({name, " result kept"}, result_o, exp_res);
    last_res = exp_res;
  endtask

  initial begin
    logic [31:0] ra, rb;
    bit rs;
    int waitn;

    vecs[0]  = '{"u100_7",     1'b0, 32'd100,       32'd7,         32'h0000000E, 32'h00000002};
    vecs[1]  = '{"s-7_2",      1'b1, 32'hFFFFFFF9,  32'h00000002,  32'hFFFFFFFD, 32'hFFFFFFFF};
    vecs[2]  = '{"smin_m1",    1'b1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000, 32'h00000000};
    vecs[3]  = '{"umin_m1",    1'b0, 32'h80000000,  32'hFFFFFFFF,  32'h00000000, 32'h80000000};
    vecs[4]  = '{"u_div0",     1'b0, 32'h12345678,  32'h00000000,  32'h00000000, 32'h00000000};
    vecs[5]  = '{"s_div0",     1'b1, 32'h80000000,  32'h00000000,  32'h00000000, 32'h00000000};
    vecs[6]  = '{"s7_m2",      1'b1, 32'h00000007,  32'hFFFFFFFE,  32'hFFFFFFFD, 32'h00000001};
    vecs[7]  = '{"s-100_-7",   1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9,  32'h0000000E, 32'hFFFFFFFE};
    vecs[8]  = '{"u_ffff_1",   1'b0, 32'hFFFFFFFF,  32'h00000001,  32'hFFFFFFFF, 32'h00000000};
    vecs[9]  = '{"u0_5",       1'b0, 32'h00000000,  32'h00000005,  32'h00000000, 32'h00000000};
    vecs[10] = '{"u3_10",      1'b0, 32'h00000003,  32'h0000000A,  32'h00000000, 32'h00000003};
    vecs[11] = '{"s-3_10",     1'b1, 32'hFFFFFFFD,  32'h0000000A,  32'h00000000, 32'hFFFFFFFD};

    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset result", result_o, 64'h0);
    check("reset ready", 64'(ready_o), 64'd0);
    check("reset busy", 64'(busy_o), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++)
      run_op(vecs[i].name, vecs[i].sgn, vecs[i].a, vecs[i].b, {vecs[i].r, vecs[i].q});

    for (int i = 0; i < 40; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = (($urandom_range(0, 3)) == 0) ? 32'($urandom_range(0, 200)) : 32'($urandom);
      case ($urandom_range(0, 7))
        0:       rb = 32'h0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFFFFFF;
        3:       begin ra = 32'h80000000; rb = 32'($urandom); end
        4:       rb = 32'($urandom) >> $urandom_range(0, 31);
        default: rb = 32'($urandom);
      endcase
      run_op($sformatf("rnd%0d", i), rs, ra, rb, model(rs, ra, rb));
    end

    // Annul during ON, sampled at E11: back to FREE, result untouched.
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    @(posedge clk); #1;  // E0
    repeat (10) @(posedge clk);
    #1;
    annul_i = 1'b1; start_i = 1'b0;
    @(posedge clk); #1;  // E11
    check("annul busy", 64'(busy_o), 64'd0);
    check("annul ready", 64'(ready_o), 64'd0);
    check("annul result", result_o, last_res);
    annul_i = 1'b0;
    @(posedge clk); #1;
    check("annul ready later", 64'(ready_o), 64'd0);
    run_op("after annul 9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3});

    // Annul in FREE blocks acceptance of start.
    annul_i = 1'b1; start_i = 1'b1; opdata1_i = 32'd50; opdata2_i = 32'd5;
    repeat (3) @(posedge clk);
    #1;
    check("annul free busy", 64'(busy_o), 64'd0);
    annul_i = 1'b0; start_i = 1'b0;
    @(posedge clk); #1;

    // Annul in END while start is still held.
    signed_div_i = 1'b0; opdata1_i = 32'd40; opdata2_i = 32'd0; start_i = 1'b1;
    waitn = 0;
    while (ready_o !== 1'b1 && waitn < 60) begin @(posedge clk); #1; waitn++; end
    check("end reached", 64'(ready_o), 64'd1);
    last_res = 64'h0;
    annul_i = 1'b1;
    @(posedge clk); #1;
    check("annul end ready", 64'(ready_o), 64'd0);
    check("annul end busy", 64'(busy_o), 64'd0);
    annul_i = 1'b0; start_i = 1'b0;
    @(posedge clk); #1;

    // Put a nonzero result in place, then reset mid-ON with start held.
    run_op("pre rst 77_5", 1'b0, 32'd77, 32'd5, {32'd2, 32'd15});
    signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
    @(posedge clk); #1;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst on result", result_o, 64'h0);
    check("rst on ready", 64'(ready_o), 64'd0);
    check("rst on busy", 64'(busy_o), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst start ignored", 64'(busy_o), 64'd0);
    rst = 1'b0; start_i = 1'b0;
    @(posedge clk); #1;

    // Reset in END.
    signed_div_i = 1'b0; opdata1_i = 32'd4; opdata2_i = 32'd2; start_i = 1'b1;
    waitn = 0;
    while (ready_o !== 1'b1 && waitn < 60) begin @(posedge clk); #1; waitn++; end
    check("rst end reached", result_o, {32'd0, 32'd2});
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst end result", result_o, 64'h0);
    check("rst end ready", 64'(ready_o), 64'd0);
    check("rst end busy", 64'(busy_o), 64'd0);
    rst = 1'b0; start_i = 1'b0;
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
